// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared bank types, bank-state constants and width helpers for the ping-pong buffer
package pingpong_pkg;
    typedef logic bank_t;
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/pp_bank.sv
// pp_bank: DEPTH x WIDTH storage bank with one write port and a registered, enabled read port
module pp_bank import pingpong_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/pingpong_buf.sv
// pingpong_buf: two-bank ping-pong buffer feeding a 2:1 word mux; producer fills one bank while the consumer drains the other
module pingpong_buf import pingpong_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    output logic             wr_ready,
    output logic             rd_avail,
    output logic [AW:0]      rd_count,
    input  logic             rd_en,
    output logic [WIDTH-1:0] bank0_rdata,
    output logic [WIDTH-1:0] bank1_rdata,
    output logic             rd_sel,
    output logic             rd_data_valid,
    output logic             rd_last
);
    bank_t            wr_bank, rd_bank;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [1:0]       full;
    logic [AW:0]      cnt [2];
    logic [WIDTH-1:0] rdata [2];
    logic             wr_acc, rd_acc, wr_close, rd_end;
    always_comb begin
        wr_ready = full[wr_bank] == EMPTY;
        rd_avail = full[rd_bank] == FULL;
        rd_count = cnt[rd_bank];
        wr_acc   = wr_valid && wr_ready;
        rd_acc   = rd_en && rd_avail;
        wr_close = wr_last || wr_addr == AW'(DEPTH - 1);
        rd_end   = {1'b0, rd_addr} == cnt[rd_bank] - (AW + 1)'(1);
    end
    // a write and a read never target the same bank, so both full-flag updates can land together
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            full          <= '0;
            cnt[0]        <= '0;
            cnt[1]        <= '0;
            rd_sel        <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_last       <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (wr_close) begin
                    full[wr_bank] <= FULL;
                    cnt[wr_bank]  <= {1'b0, wr_addr} + (AW + 1)'(1);
                    wr_addr       <= '0;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + AW'(1);
                end
            end
            if (rd_acc) begin
                if (rd_end) begin
                    full[rd_bank] <= EMPTY;
                    rd_addr       <= '0;
                    rd_bank       <= ~rd_bank;
                end else begin
                    rd_addr <= rd_addr + AW'(1);
                end
                rd_sel <= rd_bank;
            end
            rd_data_valid <= rd_acc;
            rd_last       <= rd_acc && rd_end;
        end
    end
    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
            .clk  (clk),
            .rst  (rst),
            .we   (wr_acc && wr_bank == bank_t'(b)),
            .waddr(wr_addr),
            .wdata(wr_data),
            .re   (rd_acc && rd_bank == bank_t'(b)),
            .raddr(rd_addr),
            .rdata(rdata[b])
        );
    end
    assign bank0_rdata = rdata[0];
    assign bank1_rdata = rdata[1];
endmodule

// File: tb/tb_pingpong_buf.sv
// tb_pingpong_buf: directed stimulus with a read-data scoreboard checked by an independent monitor
module tb_pingpong_buf;
    logic        clk = 1'b0;
    logic        rst, wr_valid, wr_last, rd_en;
    logic [15:0] wr_data;
    logic        wr_ready, rd_avail, rd_sel, rd_data_valid, rd_last;
    logic [4:0]  rd_count;
    logic [15:0] bank0_rdata, bank1_rdata;
    logic [17:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;

    pingpong_buf #(.WIDTH(16), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .rd_avail(rd_avail), .rd_count(rd_count), .rd_en(rd_en),
        .bank0_rdata(bank0_rdata), .bank1_rdata(bank1_rdata), .rd_sel(rd_sel),
        .rd_data_valid(rd_data_valid), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rd_data_valid) begin
            logic [17:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: got sel=%0d data=0x%0h with no read pending at %0t",
                         rd_sel, rd_sel ? bank1_rdata : bank0_rdata, $time);
            end else begin
                e = exp_q.pop_front();
                if ({rd_sel, rd_last, rd_sel ? bank1_rdata : bank0_rdata} != e) begin
                    failures++;
                    $display("FAIL rd_word: got sel=%0d last=%0d data=0x%0h expected sel=%0d last=%0d data=0x%0h at %0t",
                             rd_sel, rd_last, rd_sel ? bank1_rdata : bank0_rdata, e[17], e[16], e[15:0], $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_valid = 1'b0;
        wr_last = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data = d;
        wr_last = last;
        chk("wr_ready_on_write", int'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic rd(input logic sel, input logic [15:0] d, input logic last);
        rd_en = 1'b1;
        exp_q.push_back({sel, last, d});
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_wr_ready", int'(wr_ready), 1);
        chk("reset_rd_avail", int'(rd_avail), 0);
        chk("reset_rd_valid", int'(rd_data_valid), 0);
        chk("reset_rd_sel", int'(rd_sel), 0);
        chk("reset_bank0", int'(bank0_rdata), 0);
        chk("reset_bank1", int'(bank1_rdata), 0);

        // full fill then drain of bank 0
        for (int i = 0; i < 16; i++) wr(16'(i), 1'b0);
        chk("fill_rd_avail", int'(rd_avail), 1);
        chk("fill_rd_count", int'(rd_count), 16);
        chk("fill_wr_ready", int'(wr_ready), 1);
        for (int i = 0; i < 16; i++) rd(1'b0, 16'(i), i == 15);
        step();
        chk("drain_rd_avail", int'(rd_avail), 0);

        // ping-pong overlap
        do_reset();
        for (int i = 0; i < 16; i++) wr(16'h1000 + 16'(i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'h2000 + 16'(i);
            chk("pp_wr_ready", int'(wr_ready), 1);
            rd(1'b0, 16'h1000 + 16'(i), i == 15);
        end
        wr_valid = 1'b0;
        chk("pp_bank1_avail", int'(rd_avail), 1);
        chk("pp_bank1_count", int'(rd_count), 16);
        for (int i = 0; i < 16; i++) rd(1'b1, 16'h2000 + 16'(i), i == 15);
        step();

        // early close
        do_reset();
        wr(16'h00A0, 1'b0);
        wr(16'h00A1, 1'b0);
        wr(16'h00A2, 1'b1);
        chk("early_rd_avail", int'(rd_avail), 1);
        chk("early_rd_count", int'(rd_count), 3);
        for (int i = 0; i < 3; i++) rd(1'b0, 16'h00A0 + 16'(i), i == 2);
        chk("early_rd_avail_after", int'(rd_avail), 0);
        wr(16'h00B0, 1'b1);
        chk("early_bank1_count", int'(rd_count), 1);
        rd(1'b1, 16'h00B0, 1'b1);
        step();

        // backpressure with both banks full
        do_reset();
        for (int i = 0; i < 32; i++) wr(16'h0300 + 16'(i), 1'b0);
        chk("bp_wr_ready_low", int'(wr_ready), 0);
        wr_valid = 1'b1;
        wr_data = 16'hDEAD;
        step();
        wr_valid = 1'b0;
        chk("bp_still_blocked", int'(wr_ready), 0);
        chk("bp_rd_count", int'(rd_count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("bp_wr_ready_during_drain", int'(wr_ready), 0);
            rd(1'b0, 16'h0300 + 16'(i), i == 15);
        end
        chk("bp_wr_ready_after_drain", int'(wr_ready), 1);
        chk("bp_bank1_avail", int'(rd_avail), 1);
        for (int i = 0; i < 16; i++) rd(1'b1, 16'h0310 + 16'(i), i == 15);
        chk("bp_all_drained", int'(rd_avail), 0);
        step();

        // illegal reads while nothing is available
        do_reset();
        rd_en = 1'b1;
        step();
        chk("illegal_rd_valid", int'(rd_data_valid), 0);
        step();
        step();
        rd_en = 1'b0;
        chk("illegal_rd_valid_late", int'(rd_data_valid), 0);
        for (int i = 0; i < 4; i++) wr(16'h0040 + 16'(i), i == 3);
        chk("illegal_rd_count", int'(rd_count), 4);
        for (int i = 0; i < 4; i++) rd(1'b0, 16'h0040 + 16'(i), i == 3);
        step();

        // reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 16; i++) wr(16'h0600 + 16'(i), 1'b0);
        for (int i = 0; i < 5; i++) rd(1'b0, 16'h0600 + 16'(i), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_rd_avail", int'(rd_avail), 0);
        chk("rst_mid_wr_ready", int'(wr_ready), 1);
        chk("rst_mid_rd_valid", int'(rd_data_valid), 0);
        chk("rst_mid_rd_sel", int'(rd_sel), 0);
        for (int i = 0; i < 16; i++) wr(16'h0055 + 16'(i), 1'b0);
        chk("rst_refill_count", int'(rd_count), 16);
        for (int i = 0; i < 16; i++) rd(1'b0, 16'h0055 + 16'(i), i == 15);
        step();
        step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pingpong_buf.md
Name: pingpong_buf

Overview:
- Two-bank ping-pong buffer that sits directly upstream of the datapath 2:1 word mux.
- The producer fills one bank while the consumer drains the other. The banks swap roles automatically when each side finishes.
- The block outputs both banks' registered read words plus a bank-select that drives the mux select. Mux output = selected bank data, aligned with rd_data_valid.

Parameters:
- WIDTH, 16, data word width in bits (matches the downstream mux WIDTH).
- DEPTH, 16, words per bank; must be a power of two and at least 2.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  producer has a word.
- wr_data  input  WIDTH  producer word.
- wr_last  input  1  with an accepted write: this word closes the current bank early.
- wr_ready  output  1  fill bank can accept a word.
- rd_avail  output  1  drain bank is full/closed and holds unread words.
- rd_count  output  AW+1  number of words closed into the drain bank (valid while rd_avail).
- rd_en  input  1  consumer requests the next word; ignored unless rd_avail.
- bank0_rdata  output  WIDTH  registered read word of bank 0 (mux "zero" input).
- bank1_rdata  output  WIDTH  registered read word of bank 1 (mux "one" input).
- rd_sel  output  1  bank that produced the current read word (mux select).
- rd_data_valid  output  1  the selected bank data is valid this cycle.
- rd_last  output  1  with rd_data_valid: final word of the drained bank.

Behaviour:
- Reset state:
  - wr_bank=0, rd_bank=0, wr_addr=0, rd_addr=0.
  - full[1:0]=0, cnt0=cnt1=0.
  - rd_sel=0, rd_data_valid=0, rd_last=0, bank0_rdata=bank1_rdata=0.
  - Memory contents are not reset.
- Derived outputs:
  - wr_ready = !full[wr_bank] (combinational from state only, never from wr_valid).
  - rd_avail = full[rd_bank].
  - rd_count = cnt[rd_bank].
- Write accept (wr_valid && wr_ready):
  - mem[wr_bank][wr_addr] <= wr_data.
  - If wr_addr==DEPTH-1 or wr_last: full[wr_bank]<=1, cnt[wr_bank]<=wr_addr+1, wr_addr<=0, wr_bank<=~wr_bank.
  - Otherwise wr_addr<=wr_addr+1.
  - wr_last with no accepted write has no effect. A bank can never close with 0 words.
- Read accept (rd_en && rd_avail):
  - Read mem[rd_bank][rd_addr] into that bank's rdata register.
  - The other bank's rdata register holds its value.
  - Next cycle: rd_sel=rd_bank (old value), rd_data_valid=1, rd_last=(rd_addr==cnt[rd_bank]-1).
  - If this is the last word: full[rd_bank]<=0, rd_addr<=0, rd_bank<=~rd_bank.
  - Otherwise rd_addr<=rd_addr+1.
  - Read latency is 1 cycle; a read can be accepted every cycle.
  - rd_data_valid and rd_last fall to 0 on any cycle with no read accept.
  - rd_sel holds its last value when idle.
- Simultaneous events:
  - A write and a read in the same cycle always target different banks: the write needs the bank not full, the read needs it full. Both proceed.
  - Read freeing bank B in the same cycle the writer is stalled on full B: full clears at the edge, so wr_ready rises the next cycle. No same-cycle bypass.
  - Writer closing bank B in the same cycle the reader is idle on B: rd_avail rises the next cycle.
- Both banks full: wr_ready=0 until the reader drains one bank completely.
- rd_en while !rd_avail: ignored, no state change, rd_data_valid=0 next cycle.
- Reset mid-operation: all pointers, flags and counts clear on the next edge. Data in flight is discarded and rd_data_valid=0 the cycle after reset.
- Width rules:
  - wr_addr and rd_addr are AW bits and wrap at DEPTH only via the close condition.
  - cnt is AW+1 bits, so cnt=DEPTH is representable.

Decomposition:
- Package pingpong_pkg holds:
  - the bank index typedef (1 bit);
  - the bank-state constants EMPTY=0, FULL=1;
  - the address and count width functions derived from DEPTH.
- Sub-module pp_bank: a single-port-write, single-port-read DEPTH x WIDTH array with a registered read-data output and a read enable. It is instantiated twice. The control logic (pointers, full flags, counts, outputs) stays in pingpong_buf.

Test Plan:
- Full fill then drain, DEPTH=16:
  - Stimulus: write 0x0000..0x000F with wr_valid held.
  - Required: wr_ready stays 1; rd_avail rises the cycle after the 16th write; rd_count=16.
  - Stimulus: then assert rd_en for 16 cycles.
  - Required: bank0_rdata shows 0x0000..0x000F on successive cycles with rd_sel=0 and rd_data_valid=1; rd_last asserts on 0x000F.
- Ping-pong overlap:
  - Stimulus: fill bank 0 with 0x1000..0x100F; then write 0x2000.. continuously while reading.
  - Required: the writes go to bank 1 while bank0_rdata drains 0x1000..; then rd_sel=1 with bank1_rdata 0x2000..; no word is lost or duplicated.
- Early close:
  - Stimulus: write 0xA0,0xA1,0xA2 with wr_last on 0xA2.
  - Required: rd_count=3; reads return 0xA0,0xA1,0xA2 with rd_last on 0xA2; rd_bank toggles and wr_bank=1.
- Backpressure:
  - Stimulus: fill both banks with no reads.
  - Required: wr_ready=0 after 32 writes. A 33rd wr_valid is not accepted.
  - Stimulus: drain bank 0 fully.
  - Required: wr_ready returns to 1 exactly one cycle after the rd_en that accepts the last bank-0 word.
- Illegal read:
  - Stimulus: rd_en pulsed while rd_avail=0.
  - Required: rd_data_valid stays 0; the pointers are unchanged (checked by the following fill/drain).
- Reset mid-drain:
  - Stimulus: assert rst after 5 of 16 reads.
  - Required: the next cycle has rd_avail=0, wr_ready=1, rd_data_valid=0, rd_sel=0. A new fill of 0x55.. reads back correctly from bank 0.
